// File: rtl/div_if.sv
// EX-stage <-> divider sequencer handshake: divide request in, stall/busy and result out.
interface div_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] opa_i;
  logic [WIDTH-1:0] opb_i;
  logic             flush_i;
  logic             stall_o;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] quot_o;
  logic [WIDTH-1:0] rem_o;

  modport master (output start_i, signed_i, opa_i, opb_i, flush_i,
                  input  stall_o, busy_o, valid_o, quot_o, rem_o);
  modport slave  (input  start_i, signed_i, opa_i, opb_i, flush_i,
                  output stall_o, busy_o, valid_o, quot_o, rem_o);
endinterface

// File: rtl/div_ctrl.sv
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per cycle on
// magnitudes, sign fix-up on the way into DONE, single-cycle result strobe.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  resetn,
  div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ON, DONE} state_t;
  state_t state;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q, quo_q, absb;
  logic             neg_q, neg_r;
  logic             accept, ge;
  logic [WIDTH-1:0] absa_in, absb_in, rem_nx, quo_nx;
  logic [WIDTH:0]   trial;

  assign accept   = (state == IDLE) & bus.start_i & ~bus.flush_i;
  assign bus.stall_o = resetn & (accept | (state == ON));
  assign bus.busy_o  = (state != IDLE);

  assign absa_in = (bus.signed_i & bus.opa_i[WIDTH-1]) ? -bus.opa_i : bus.opa_i;
  assign absb_in = (bus.signed_i & bus.opb_i[WIDTH-1]) ? -bus.opb_i : bus.opb_i;

  // Partial remainder can reach 2*|b|-1 after the shift, hence the extra bit.
  assign trial  = {rem_q, quo_q[WIDTH-1]};
  assign ge     = (trial >= {1'b0, absb});
  assign rem_nx = ge ? (trial[WIDTH-1:0] - absb) : trial[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], ge};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      absb        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      bus.valid_o <= 1'b0;
      bus.quot_o  <= '0;
      bus.rem_o   <= '0;
    end else begin
      bus.valid_o <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          neg_q <= bus.signed_i & (bus.opa_i[WIDTH-1] ^ bus.opb_i[WIDTH-1]);
          neg_r <= bus.signed_i & bus.opa_i[WIDTH-1];
          absb  <= absb_in;
          quo_q <= absa_in;
          rem_q <= '0;
          cnt   <= '0;
          if (bus.opb_i == '0) begin
            // Divide-by-zero: defined result, no iterations.
            bus.quot_o  <= '1;
            bus.rem_o   <= bus.opa_i;
            bus.valid_o <= 1'b1;
            state       <= DONE;
          end else begin
            state <= ON;
          end
        end
        ON: if (bus.flush_i) begin
          state <= IDLE;
        end else begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            bus.quot_o  <= neg_q ? -quo_nx : quo_nx;
            bus.rem_o   <= neg_r ? -rem_nx : rem_nx;
            bus.valid_o <= 1'b1;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: results queued at issue, checked on valid_o.
module tb_div_ctrl;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  div_if #(.WIDTH(32)) bus ();
  div_ctrl #(.WIDTH(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int          n_chk = 0, n_err = 0;
  int          cyc = 0, vcyc = 0, vcyc_prev = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_m;
  logic [63:0] last_res;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (!sg) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
    return {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
  endfunction

  always @(negedge clk) begin
    if (resetn && bus.valid_o) begin
      vcyc_prev = vcyc;
      vcyc      = cyc;
      if (sb.size() == 0) chk("sb_empty", 64'(sb.size()), 64'd1);
      else begin
        exp_m = sb.pop_front();
        chk("quot", 64'(bus.quot_o), 64'(exp_m[63:32]));
        chk("rem",  64'(bus.rem_o),  64'(exp_m[31:0]));
      end
    end
  end

  // Issue one divide in the current cycle; returns in the IDLE cycle after DONE.
  // Operands are scrambled mid-operation to confirm they were latched.
  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input bit hold);
    int n;
    bit stall_bad;
    bus.signed_i = sg; bus.opa_i = a; bus.opb_i = b; bus.start_i = 1'b1; bus.flush_i = 1'b0;
    last_res = model(sg, a, b);
    sb.push_back(last_res);
    @(negedge clk);
    chk("stall_acc", 64'(bus.stall_o), 64'd1);
    chk("valid_idle", 64'(bus.valid_o), 64'd0);
    n = 0; stall_bad = 0;
    while (!bus.valid_o && n < 100) begin
      @(posedge clk); #1; n++;
      if (n == 5) begin bus.opa_i = ~a; bus.opb_i = b + 32'd1; bus.signed_i = ~sg; end
      @(negedge clk);
      if (!bus.valid_o && !bus.stall_o) stall_bad = 1;
    end
    chk("latency", 64'(n), 64'(lat));
    chk("stall_on", 64'(stall_bad), 64'd0);
    chk("stall_done", 64'(bus.stall_o), 64'd0);
    if (!hold) bus.start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] ra, rb;
    int nv;
    resetn = 1'b0;
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.opa_i = 32'd5; bus.opb_i = 32'd1; bus.flush_i = 1'b0;
    #1;
    chk("rst_busy",  64'(bus.busy_o),  64'd0);
    chk("rst_stall", 64'(bus.stall_o), 64'd0);
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_quot",  64'(bus.quot_o),  64'd0);
    chk("rst_rem",   64'(bus.rem_o),   64'd0);
    @(posedge clk); @(posedge clk); #1;
    bus.start_i = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;

    do_div(1'b0, 32'd100, 32'd7, 33, 1'b0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 33, 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b0);
    do_div(1'b1, 32'd100, 32'hFFFF_FFF9, 33, 1'b0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
    do_div(1'b0, 32'h1234, 32'd0, 1, 1'b0);
    do_div(1'b1, 32'hFFFF_FF00, 32'd0, 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == 32'd0) rb = 32'd3;
      do_div(1'(i), ra, rb, 33, 1'b0);
    end

    // back-to-back: start held through DONE
    do_div(1'b0, 32'd1000, 32'd7, 33, 1'b1);
    do_div(1'b0, 32'd50, 32'd5, 33, 1'b0);
    chk("b2b_gap", 64'(vcyc - vcyc_prev), 64'd34);

    // flush at cycle 10 of an operation
    bus.signed_i = 1'b0; bus.opa_i = 32'd1000; bus.opb_i = 32'd3; bus.start_i = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 10; i++) begin @(posedge clk); #1; end
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("flush_busy_on", 64'(bus.busy_o), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_busy", 64'(bus.busy_o), 64'd0);
    chk("flush_stall", 64'(bus.stall_o), 64'd0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0; bus.start_i = 1'b0;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.valid_o) nv++;
    end
    chk("flush_novalid", 64'(nv), 64'd0);
    chk("flush_hold", {bus.quot_o, bus.rem_o}, last_res);
    @(posedge clk); #1;
    do_div(1'b0, 32'd1000, 32'd3, 33, 1'b0);

    // asynchronous reset mid-operation
    bus.signed_i = 1'b0; bus.opa_i = 32'd12345; bus.opb_i = 32'd67; bus.start_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin @(posedge clk); #1; end
    #2 resetn = 1'b0;
    bus.start_i = 1'b0;
    #1;
    chk("arst_busy",  64'(bus.busy_o),  64'd0);
    chk("arst_stall", 64'(bus.stall_o), 64'd0);
    chk("arst_valid", 64'(bus.valid_o), 64'd0);
    chk("arst_quot",  64'(bus.quot_o),  64'd0);
    chk("arst_rem",   64'(bus.rem_o),   64'd0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    do_div(1'b0, 32'd9, 32'd4, 33, 1'b0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_chk);
    $fatal(1);
  end
endmodule
